write_b_in: RTL and testbench
=============================

WRITE_B_IN -- requirements
Module: write_b_in

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 64, user payload width excluding the valid bit.
REQ-002 SHALL have parameter NUM_ADDR_BITS, default 7, log2 of total entries across both banks; each bank has 2^(NUM_ADDR_BITS-1) entries.
REQ-003 SHALL have parameter FREESPACE_UPDATE_SIZE, default 64, entries returned per freespace_update pulse.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port din, input, PAYLOAD_BITS, payload from network side.
REQ-007 SHALL have port vld_in, input, 1, din valid.
REQ-008 SHALL have port rdy_out, output, 1, block can accept din this cycle.
REQ-009 SHALL have port freespace_update, input, 1, single-cycle pulse from the bank reader: FREESPACE_UPDATE_SIZE entries were freed.
REQ-010 SHALL have ports addra_0 and addra_1, output, NUM_ADDR_BITS-1 each, bank write addresses.
REQ-011 SHALL have ports dina_0 and dina_1, output, PAYLOAD_BITS+1 each, {valid bit, payload}.
REQ-012 SHALL have ports wea_0 and wea_1, output, 1 each, bank write enables.
REQ-013 SHALL have port credits, output, NUM_ADDR_BITS+1, free entries remaining.
REQ-014 SHALL have port overflow_err, output, 1, sticky credit-overflow flag.

Function
REQ-015 SHALL implement a two-state FSM, W0 (next write to bank 0) and W1 (next write to bank 1).
REQ-016 SHALL define accept = vld_in && rdy_out.
REQ-017 SHALL transition W0->W1 or W1->W0 on the clock edge after each accept, and hold state otherwise.
REQ-018 SHALL drive wea_0 combinationally = accept && state==W0, and wea_1 = accept && state==W1; both never high together.
REQ-019 SHALL drive dina_0 and dina_1 combinationally = {1'b1, din} (valid bit MSB set).
REQ-020 SHALL increment the written bank's address register on the edge after an accept; the other bank's address holds.
REQ-021 SHALL wrap addresses modulo 2^(NUM_ADDR_BITS-1) (all-ones -> 0), with no flag.
REQ-022 SHALL drive rdy_out combinationally = (credits != 0).
REQ-023 SHALL update credits per cycle: accept only -> -1; freespace_update only -> +FREESPACE_UPDATE_SIZE; both -> +FREESPACE_UPDATE_SIZE-1; neither -> hold.
REQ-024 SHALL saturate credits at 2^NUM_ADDR_BITS; an update exceeding that value SHALL set overflow_err, which stays high until reset.
REQ-025 SHALL reflect a freed-space return in rdy_out one cycle after the freespace_update pulse; zero-cycle credit bypass is not permitted.

Reset
REQ-026 SHALL on reset set: state=W0, addra_0=addra_1=0, credits=2^NUM_ADDR_BITS, overflow_err=0.
REQ-027 SHALL, while reset is high, hold wea_0=wea_1=0 regardless of vld_in; a reset mid-stream discards any in-progress write.

Configuration
REQ-028 SHALL, with macro WRITE_B_IN_CREDIT_EN defined, implement the credit counter, credit gating and overflow_err as in REQ-022..REQ-025.
REQ-029 SHALL, without WRITE_B_IN_CREDIT_EN, tie rdy_out=1, credits=0 and overflow_err=0, and ignore freespace_update; upstream then owns flow control.

Structure
REQ-030 SHALL place state encodings W0/W1 and the default parameter values in the shared leaf-interface package used by the bank reader.
REQ-031 SHALL implement the credit counter as one sub-module, write_b_in_credit, instantiated only when WRITE_B_IN_CREDIT_EN is defined.

Verification
REQ-032 SHALL cover: after reset, 4 back-to-back accepts of din=1..4 -> wea_0,wea_1,wea_0,wea_1; bank 0 addr 0,1 = {1,1},{1,3}; bank 1 addr 0,1 = {1,2},{1,4}.
REQ-033 SHALL cover: 128 accepts with no freespace_update (defaults) -> credits=0, rdy_out=0, no wea while vld_in stays high.
REQ-034 SHALL cover: at credits=0, a freespace_update pulse -> credits=64 and rdy_out=1 on the next cycle.
REQ-035 SHALL cover: accept and freespace_update in the same cycle at credits=10 -> credits=73.
REQ-036 SHALL cover: freespace_update at credits=128 -> credits stays 128, overflow_err=1 and it stays high.
REQ-037 SHALL cover: 64 accepts per bank -> addresses wrap 63->0; reset asserted mid-stream -> state W0, addresses 0, credits 128.

Source files
------------

// File: rtl/write_b_in_pkg.sv
// Shared leaf-interface package for the write_b_in block and its bank reader.
// It holds the bank-select state encoding, the default parameter values and
// a small helper that names the bank that follows the current one.
package write_b_in_pkg;

    // Selects the bank that takes the next accepted write.
    typedef enum logic {
        W0 = 1'b0,
        W1 = 1'b1
    } wr_state_t;

    localparam int DEF_PAYLOAD_BITS          = 64;
    localparam int DEF_NUM_ADDR_BITS         = 7;
    localparam int DEF_FREESPACE_UPDATE_SIZE = 64;

    // Writes alternate between the two banks.
    function automatic wr_state_t other_bank(input wr_state_t s);
        return (s == W0) ? W1 : W0;
    endfunction

endpackage

// File: rtl/write_b_in_credit.sv
// Credit counter for write_b_in. It tracks the number of free entries across
// both banks. An accepted write consumes one credit, and a freespace_update
// pulse returns FREESPACE_UPDATE_SIZE credits. The count saturates at the
// total capacity. A return that would exceed the capacity raises a sticky
// overflow flag, which clears only on reset.
module write_b_in_credit
    import write_b_in_pkg::*;
#(
    parameter int NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS,
    parameter int FREESPACE_UPDATE_SIZE = DEF_FREESPACE_UPDATE_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     accept,
    input  logic                     freespace_update,
    output logic [NUM_ADDR_BITS:0]   credits,
    output logic                     overflow_err
);

    localparam int CW = NUM_ADDR_BITS + 1;
    // One extra bit of headroom, so that an overshoot past the capacity is
    // visible before it is clamped.
    localparam int SW = NUM_ADDR_BITS + 2;
    localparam logic [SW-1:0] MAX_CREDITS = SW'(1) << NUM_ADDR_BITS;
    localparam logic [SW-1:0] RETURN_SIZE = SW'(FREESPACE_UPDATE_SIZE);

    logic [CW-1:0] credits_reg;
    logic [CW-1:0] credits_next;
    logic          overflow_reg;
    logic          overflow_next;
    logic [SW-1:0] sum;

    // Next credit value: apply the return and the consumption, then clamp to capacity.
    always_comb begin
        sum           = {1'b0, credits_reg};
        credits_next  = credits_reg;
        overflow_next = overflow_reg;
        if (freespace_update) begin
            sum = sum + RETURN_SIZE;
        end
        if (accept) begin
            sum = sum - SW'(1);
        end
        if (sum > MAX_CREDITS) begin
            credits_next  = MAX_CREDITS[CW-1:0];
            overflow_next = 1'b1;
        end else begin
            credits_next  = sum[CW-1:0];
        end
    end

    // Credit and overflow registers; reset leaves every entry free.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits_reg  <= MAX_CREDITS[CW-1:0];
            overflow_reg <= 1'b0;
        end else begin
            credits_reg  <= credits_next;
            overflow_reg <= overflow_next;
        end
    end

    assign credits      = credits_reg;
    assign overflow_err = overflow_reg;

endmodule

// File: rtl/write_b_in.sv
// write_b_in: takes payloads from the network side and writes them in turn
// into two banks (bank 0, then bank 1). Each stored word is {valid, payload}.
// Optional feature macro: WRITE_B_IN_CREDIT_EN.
//   When the macro is defined, a credit counter gates rdy_out and flags overflow.
//   When the macro is not defined, rdy_out is always 1 and upstream owns flow control.
module write_b_in
    import write_b_in_pkg::*;
#(
    parameter int PAYLOAD_BITS          = DEF_PAYLOAD_BITS,
    parameter int NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS,
    parameter int FREESPACE_UPDATE_SIZE = DEF_FREESPACE_UPDATE_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PAYLOAD_BITS-1:0]   din,
    input  logic                      vld_in,
    output logic                      rdy_out,
    input  logic                      freespace_update,
    output logic [NUM_ADDR_BITS-2:0]  addra_0,
    output logic [NUM_ADDR_BITS-2:0]  addra_1,
    output logic [PAYLOAD_BITS:0]     dina_0,
    output logic [PAYLOAD_BITS:0]     dina_1,
    output logic                      wea_0,
    output logic                      wea_1,
    output logic [NUM_ADDR_BITS:0]    credits,
    output logic                      overflow_err
);

    localparam int AW = NUM_ADDR_BITS - 1;

    wr_state_t  state_reg;
    wr_state_t  state_next;
    logic       accept;
    logic [1:0] bank_we;

    // A write happens only when the bank side can take it. Reset forces the
    // write enables low, so a write that is in progress during reset is dropped.
    assign accept = vld_in && rdy_out && !reset;

    // Bank-select state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= W0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Steer the accepted write to the current bank, and move on to the other bank.
    always_comb begin
        state_next = state_reg;
        bank_we    = 2'b00;
        if (accept) begin
            state_next = other_bank(state_reg);
            bank_we[0] = (state_reg == W0);
            bank_we[1] = (state_reg == W1);
        end
    end

    // One address counter per bank. Each counter wraps silently at the bank depth.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_bank
        logic [AW-1:0] addr_reg;

        // Advance this bank's address after each write that lands in this bank.
        always_ff @(posedge clk) begin
            if (reset) begin
                addr_reg <= '0;
            end else if (bank_we[gi]) begin
                addr_reg <= addr_reg + AW'(1);
            end
        end
    end

    assign addra_0 = gen_bank[0].addr_reg;
    assign addra_1 = gen_bank[1].addr_reg;
    assign wea_0   = bank_we[0];
    assign wea_1   = bank_we[1];
    assign dina_0  = {1'b1, din};
    assign dina_1  = {1'b1, din};

`ifdef WRITE_B_IN_CREDIT_EN
    write_b_in_credit #(
        .NUM_ADDR_BITS         (NUM_ADDR_BITS),
        .FREESPACE_UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
    ) u_credit (
        .clk              (clk),
        .reset            (reset),
        .accept           (accept),
        .freespace_update (freespace_update),
        .credits          (credits),
        .overflow_err     (overflow_err)
    );

    // Credits are registered, so a freed-space return reaches rdy_out one cycle later.
    assign rdy_out = (credits != '0);
`else
    logic unused_freespace_update;

    assign unused_freespace_update = freespace_update;
    assign rdy_out                 = 1'b1;
    assign credits                 = '0;
    assign overflow_err            = 1'b0;
`endif

endmodule

// File: tb/tb_write_b_in.sv
// Testbench for write_b_in. The design uses its default parameters.
// A transaction-level model counts the accepted writes and the free entries.
// A compare process checks every DUT output against this model on each falling clock edge.
// Directed steps with hand-computed literal values pin the model itself.
module tb_write_b_in;

    localparam int PB    = 64;
    localparam int NAB   = 7;
    localparam int FUS   = 64;
    localparam int DEPTH = 1 << (NAB - 1);
    localparam int CAP   = 1 << NAB;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [PB-1:0]      din = '0;
    logic               vld_in = 1'b0;
    logic               rdy_out;
    logic               freespace_update = 1'b0;
    logic [NAB-2:0]     addra_0;
    logic [NAB-2:0]     addra_1;
    logic [PB:0]        dina_0;
    logic [PB:0]        dina_1;
    logic               wea_0;
    logic               wea_1;
    logic [NAB:0]       credits;
    logic               overflow_err;

    int checks = 0;
    int errors = 0;
    bit credit_en;

    write_b_in #(
        .PAYLOAD_BITS          (PB),
        .NUM_ADDR_BITS         (NAB),
        .FREESPACE_UPDATE_SIZE (FUS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .din              (din),
        .vld_in           (vld_in),
        .rdy_out          (rdy_out),
        .freespace_update (freespace_update),
        .addra_0          (addra_0),
        .addra_1          (addra_1),
        .dina_0           (dina_0),
        .dina_1           (dina_1),
        .wea_0            (wea_0),
        .wea_1            (wea_1),
        .credits          (credits),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_count   = 0;     // number of writes accepted since reset
    int m_credits = CAP;   // number of free entries
    bit m_ovf     = 1'b0;

    function automatic bit m_rdy();
        return credit_en ? (m_credits != 0) : 1'b1;
    endfunction

    always @(posedge clk) begin
        int  nc;
        bit  acc;
        if (reset) begin
            m_count   <= 0;
            m_credits <= CAP;
            m_ovf     <= 1'b0;
        end else begin
            acc = vld_in && m_rdy();
            if (acc) m_count <= m_count + 1;
            nc = m_credits + (freespace_update ? FUS : 0) - (acc ? 1 : 0);
            if (nc > CAP) begin
                m_credits <= CAP;
                m_ovf     <= 1'b1;
            end else begin
                m_credits <= nc;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        bit acc;
        acc = !reset && vld_in && m_rdy();
        chk("m_wea_0", 128'(wea_0), 128'(acc && (m_count % 2 == 0)));
        chk("m_wea_1", 128'(wea_1), 128'(acc && (m_count % 2 == 1)));
        chk("m_addra_0", 128'(addra_0), 128'(((m_count + 1) / 2) % DEPTH));
        chk("m_addra_1", 128'(addra_1), 128'((m_count / 2) % DEPTH));
        chk("m_dina_0", 128'(dina_0), 128'({1'b1, din}));
        chk("m_dina_1", 128'(dina_1), 128'({1'b1, din}));
        chk("m_rdy_out", 128'(rdy_out), 128'(m_rdy()));
        chk("m_credits", 128'(credits), credit_en ? 128'(m_credits) : 128'(0));
        chk("m_overflow", 128'(overflow_err), credit_en ? 128'(m_ovf) : 128'(0));
    end

    // One stimulus cycle: apply the inputs just after a rising edge, then settle.
    task automatic cyc(input bit r, input bit v, input logic [PB-1:0] d, input bit fu);
        @(posedge clk);
        #2;
        reset = r; vld_in = v; din = d; freespace_update = fu;
        #1;
    endtask

    initial begin
`ifdef WRITE_B_IN_CREDIT_EN
        credit_en = 1'b1;
`else
        credit_en = 1'b0;
`endif
        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_addra_0", 128'(addra_0), 128'(0));
        chk("rst_addra_1", 128'(addra_1), 128'(0));
        chk("rst_credits", 128'(credits), credit_en ? 128'(128) : 128'(0));
        chk("rst_rdy", 128'(rdy_out), 128'(1));
        chk("rst_ovf", 128'(overflow_err), 128'(0));
        $display("txn reset done");

        // Four back-to-back writes alternate banks
        cyc(0, 1, 1, 0);
        chk("bb1_wea", 128'({wea_0, wea_1}), 128'(2'b10));
        chk("bb1_addr", 128'(addra_0), 128'(0));
        chk("bb1_dina", 128'(dina_0), {63'd0, 65'h1_0000_0000_0000_0001});
        $display("txn write din=1 bank0 addr=%0d", addra_0);
        cyc(0, 1, 2, 0);
        chk("bb2_wea", 128'({wea_0, wea_1}), 128'(2'b01));
        chk("bb2_addr", 128'(addra_1), 128'(0));
        chk("bb2_dina", 128'(dina_1), {63'd0, 65'h1_0000_0000_0000_0002});
        $display("txn write din=2 bank1 addr=%0d", addra_1);
        cyc(0, 1, 3, 0);
        chk("bb3_wea", 128'({wea_0, wea_1}), 128'(2'b10));
        chk("bb3_addr", 128'(addra_0), 128'(1));
        chk("bb3_dina", 128'(dina_0), {63'd0, 65'h1_0000_0000_0000_0003});
        $display("txn write din=3 bank0 addr=%0d", addra_0);
        cyc(0, 1, 4, 0);
        chk("bb4_wea", 128'({wea_0, wea_1}), 128'(2'b01));
        chk("bb4_addr", 128'(addra_1), 128'(1));
        chk("bb4_dina", 128'(dina_1), {63'd0, 65'h1_0000_0000_0000_0004});
        $display("txn write din=4 bank1 addr=%0d", addra_1);
        cyc(0, 0, 0, 0);
        chk("bb_credits", 128'(credits), credit_en ? 128'(124) : 128'(0));

        // Reset with vld_in high: no write enables
        cyc(1, 1, 9, 0);
        chk("rst_vld_wea", 128'({wea_0, wea_1}), 128'(0));
        $display("txn reset with vld_in high");

        // 128 writes: addresses wrap, credits run out
        for (int i = 0; i < 128; i++) begin
            cyc(0, 1, PB'(i + 100), 0);
        end
        cyc(0, 1, 99, 0);
        chk("wrap_addra_0", 128'(addra_0), 128'(0));
        chk("wrap_addra_1", 128'(addra_1), 128'(0));
        chk("drain_credits", 128'(credits), 128'(0));
        chk("drain_rdy", 128'(rdy_out), credit_en ? 128'(0) : 128'(1));
        chk("drain_wea_0", 128'(wea_0), credit_en ? 128'(0) : 128'(1));
        $display("txn 128 writes done addra_0=%0d addra_1=%0d credits=%0d", addra_0, addra_1, credits);
        cyc(0, 1, 98, 0);
        cyc(0, 0, 0, 0);

        // Freespace return at zero credits; no same-cycle bypass
        cyc(0, 0, 0, 1);
        chk("fu_nobypass_rdy", 128'(rdy_out), credit_en ? 128'(0) : 128'(1));
        cyc(0, 0, 0, 0);
        chk("fu_credits", 128'(credits), credit_en ? 128'(64) : 128'(0));
        chk("fu_rdy", 128'(rdy_out), 128'(1));
        $display("txn freespace_update credits=%0d", credits);

        // Bring the count down to 10, then accept and return in the same cycle
        for (int i = 0; i < 54; i++) begin
            cyc(0, 1, PB'(i), 0);
        end
        cyc(0, 0, 0, 0);
        chk("ten_credits", 128'(credits), credit_en ? 128'(10) : 128'(0));
        cyc(0, 1, 55, 1);
        cyc(0, 0, 0, 0);
        chk("both_credits", 128'(credits), credit_en ? 128'(73) : 128'(0));
        $display("txn accept+freespace credits=%0d", credits);

        // Return at full credits: saturate and set the sticky overflow flag
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("full_credits", 128'(credits), credit_en ? 128'(128) : 128'(0));
        cyc(0, 0, 0, 0);
        chk("ovf_credits", 128'(credits), credit_en ? 128'(128) : 128'(0));
        chk("ovf_set", 128'(overflow_err), credit_en ? 128'(1) : 128'(0));
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 5, 0);
        cyc(0, 0, 0, 0);
        chk("ovf_sticky", 128'(overflow_err), credit_en ? 128'(1) : 128'(0));
        chk("ovf_after_acc", 128'(credits), credit_en ? 128'(127) : 128'(0));
        $display("txn overflow credits=%0d overflow_err=%0d", credits, overflow_err);

        // Reset in the middle of a stream
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, PB'(i + 200), 0);
        end
        cyc(1, 1, 7, 0);
        chk("mid_rst_wea", 128'({wea_0, wea_1}), 128'(0));
        cyc(1, 1, 7, 0);
        cyc(0, 0, 0, 0);
        chk("mid_addra_0", 128'(addra_0), 128'(0));
        chk("mid_addra_1", 128'(addra_1), 128'(0));
        chk("mid_credits", 128'(credits), credit_en ? 128'(128) : 128'(0));
        chk("mid_ovf", 128'(overflow_err), 128'(0));
        cyc(0, 1, 7, 0);
        chk("mid_first_wea", 128'({wea_0, wea_1}), 128'(2'b10));
        $display("txn mid-stream reset recovered");
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
